// File: rtl/stage_sequencer_if.sv
// Handshake and status bundle between the stage sequencer and its host.
// The master side drives the memory/debug requests; the slave side reports stage and counters.
interface stage_sequencer_if;
    logic        mem_ready;
    logic        is_mem_instr;
    logic        halt_req;
    logic        step_req;
    logic [4:0]  stage;
    logic        halted;
    logic        retire;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    modport master (
        output mem_ready, is_mem_instr, halt_req, step_req,
        input  stage, halted, retire, cycle_count, instr_count
    );

    modport slave (
        input  mem_ready, is_mem_instr, halt_req, step_req,
        output stage, halted, retire, cycle_count, instr_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer with halt control and cycle/retire counters.
// Define STAGE_SEQ_STEP_EN to enable single-stepping out of HALTED on a step_req rising edge.
module stage_sequencer (
    input  logic             clock,
    input  logic             reset,
    stage_sequencer_if.slave bus
);
    // state  | meaning
    // INSTR  | fetch; holds until mem_ready
    // DECODE | single cycle
    // EXE    | single cycle
    // DATA   | single cycle, or holds for mem_ready on a load/store
    // REG    | writeback; retire pulse, halt decision point
    // HALTED | parked until halt_req drops or a step edge arrives
    typedef enum logic [2:0] {
        INSTR  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        DATA   = 3'd3,
        REG    = 3'd4,
        HALTED = 3'd5
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  stage_q;
    logic        halted_q;
    logic        retire_q;
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] instr_cnt_q;
    logic [31:0] instr_cnt_d;
    logic        step_go;

`ifdef STAGE_SEQ_STEP_EN
    logic step_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.step_req;
        end
    end

    assign step_go = bus.step_req & ~step_q;
`else
    logic unused_step_req;

    assign unused_step_req = bus.step_req;
    assign step_go         = 1'b0;
`endif

    function automatic logic [4:0] stage_code(input state_t s);
        logic [4:0] code;
        case (s)
            INSTR:   code = 5'b00001;
            DECODE:  code = 5'b00010;
            EXE:     code = 5'b00100;
            DATA:    code = 5'b01000;
            REG:     code = 5'b10000;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

    // Halt is only honoured at REG so an instruction in flight always completes.
    always_comb begin
        state_d = INSTR;
        case (state_q)
            INSTR:   state_d = bus.mem_ready ? DECODE : INSTR;
            DECODE:  state_d = EXE;
            EXE:     state_d = DATA;
            DATA:    state_d = (bus.is_mem_instr && !bus.mem_ready) ? DATA : REG;
            REG:     state_d = bus.halt_req ? HALTED : INSTR;
            HALTED:  state_d = (!bus.halt_req || step_go) ? INSTR : HALTED;
            default: state_d = INSTR;
        endcase
    end

    assign cycle_cnt_d = cycle_cnt_q + {31'd0, (state_q != HALTED)};
    assign instr_cnt_d = instr_cnt_q + {31'd0, retire_q};

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INSTR;
            stage_q     <= 5'b00001;
            halted_q    <= 1'b0;
            retire_q    <= 1'b0;
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_code(state_d);
            halted_q    <= (state_d == HALTED);
            retire_q    <= (state_d == REG);
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign bus.stage       = stage_q;
    assign bus.halted      = halted_q;
    assign bus.retire      = retire_q;
    assign bus.cycle_count = cycle_cnt_q;
    assign bus.instr_count = instr_cnt_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: expected stage/counter values are queued per cycle
// from a small reference model and compared at the falling edge.
module tb_stage_sequencer;
    logic clock = 1'b0;
    logic reset;

    stage_sequencer_if sif ();

    stage_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  stage;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] m_cyc;
    logic [31:0] m_ins;
    int          checks   = 0;
    int          failures = 0;
    int          retires  = 0;
    logic [4:0]  pat [5]  = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
    logic [4:0]  step_exp [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue what the current cycle should show, then advance the model past its clock edge.
    task automatic push(input logic [4:0] s);
        exp_t e;
        e.stage = s;
        e.cyc   = m_cyc;
        e.ins   = m_ins;
        sb_q.push_back(e);
        if (s != 5'h00) m_cyc++;
        if (s == 5'h10) m_ins++;
    endtask

    task automatic observe(input string tag);
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            failures++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_stage"},  32'(sif.stage),  32'(e.stage));
        chk({tag, "_halted"}, 32'(sif.halted), 32'(e.stage == 5'h00));
        chk({tag, "_retire"}, 32'(sif.retire), 32'(e.stage == 5'h10));
        chk({tag, "_cyc"},    sif.cycle_count, e.cyc);
        chk({tag, "_ins"},    sif.instr_count, e.ins);
        if (sif.retire === 1'b1) retires++;
    endtask

    task automatic nxt(input logic [4:0] s, input string tag);
        @(negedge clock);
        push(s);
        observe(tag);
    endtask

    task automatic do_reset(input logic halt, input string tag);
        reset            = 1'b1;
        sif.mem_ready    = 1'b1;
        sif.is_mem_instr = 1'b0;
        sif.halt_req     = halt;
        sif.step_req     = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        sb_q.delete();
        m_cyc = 32'd0;
        m_ins = 32'd0;
        push(5'h01);
        observe(tag);
    endtask

    initial begin
        m_cyc = 32'd0;
        m_ins = 32'd0;
`ifdef STAGE_SEQ_STEP_EN
        step_exp = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
`else
        step_exp = '{default: 5'h00};
`endif

        // Straight-line ALU instructions.
        do_reset(1'b0, "rst0");
        for (int i = 1; i <= 20; i++) nxt(pat[i % 5], "basic");
        chk("basic_cyc20", sif.cycle_count, 32'd20);
        chk("basic_ins4",  sif.instr_count, 32'd4);

        // Fetch stall.
        sif.mem_ready = 1'b0;
        nxt(5'h01, "fstall");
        nxt(5'h01, "fstall");
        sif.mem_ready = 1'b1;
        nxt(5'h02, "fstall");
        nxt(5'h04, "fstall");
        nxt(5'h08, "fstall");
        nxt(5'h10, "fstall");
        nxt(5'h01, "fstall");

        // Halt raised during EXE completes the instruction first.
        nxt(5'h02, "halt");
        nxt(5'h04, "halt");
        sif.halt_req = 1'b1;
        nxt(5'h08, "halt");
        nxt(5'h10, "halt");
        nxt(5'h00, "halt");
        nxt(5'h00, "halt");
        nxt(5'h00, "halt");
        sif.halt_req = 1'b0;
        nxt(5'h01, "unhalt");
        nxt(5'h02, "unhalt");
        nxt(5'h04, "unhalt");

        // Load/store with memory wait in DATA.
        do_reset(1'b0, "rst1");
        sif.is_mem_instr = 1'b1;
        nxt(5'h02, "mem");
        nxt(5'h04, "mem");
        sif.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) nxt(5'h08, "mem_wait");
        sif.mem_ready = 1'b1;
        nxt(5'h10, "mem");
        nxt(5'h01, "mem");
        chk("mem_cyc8", sif.cycle_count, 32'd8);
        chk("mem_ins1", sif.instr_count, 32'd1);

        // Non-memory DATA ignores mem_ready.
        sif.is_mem_instr = 1'b0;
        nxt(5'h02, "alu_nr");
        nxt(5'h04, "alu_nr");
        sif.mem_ready = 1'b0;
        nxt(5'h08, "alu_nr");
        nxt(5'h10, "alu_nr");
        sif.mem_ready = 1'b1;
        nxt(5'h01, "alu_nr");

        // Reset during a stalled DATA stage.
        sif.is_mem_instr = 1'b1;
        nxt(5'h02, "pre_rst");
        nxt(5'h04, "pre_rst");
        sif.mem_ready = 1'b0;
        nxt(5'h08, "pre_rst");
        nxt(5'h08, "pre_rst");
        do_reset(1'b0, "rst_data");

        // halt_req held through reset still lets the first instruction finish.
        do_reset(1'b1, "rst_halt");
        nxt(5'h02, "hold_halt");
        nxt(5'h04, "hold_halt");
        nxt(5'h08, "hold_halt");
        nxt(5'h10, "hold_halt");
        nxt(5'h00, "hold_halt");
        nxt(5'h00, "hold_halt");
        do_reset(1'b1, "rst_in_halted");
        nxt(5'h02, "rehalt");
        nxt(5'h04, "rehalt");
        nxt(5'h08, "rehalt");
        nxt(5'h10, "rehalt");
        nxt(5'h00, "rehalt");

        // step_req held high while halted.
        retires = 0;
        sif.step_req = 1'b1;
        for (int i = 0; i < 10; i++) nxt(step_exp[i], "step");
`ifdef STAGE_SEQ_STEP_EN
        chk("step_retires", 32'(retires), 32'd1);
`else
        chk("step_retires", 32'(retires), 32'd0);
`endif
        sif.step_req = 1'b0;
        nxt(5'h00, "step_end");
        sif.halt_req = 1'b0;
        nxt(5'h01, "exit");

        // Counter wrap: preload each counter through its next-value path.
        force dut.cycle_cnt_d = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
        nxt(5'h02, "cwrap");
        release dut.cycle_cnt_d;
        nxt(5'h04, "cwrap");
        chk("cyc_wrap", sif.cycle_count, 32'd0);
        force dut.instr_cnt_d = 32'hFFFF_FFFF;
        m_ins = 32'hFFFF_FFFF;
        nxt(5'h08, "iwrap");
        release dut.instr_cnt_d;
        nxt(5'h10, "iwrap");
        nxt(5'h01, "iwrap");
        chk("ins_wrap", sif.instr_count, 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
